// File: rtl/audio_level_meter_pkg.sv
// audio_meter_pkg: shared widths, full-scale constants, magnitude/height types
// and the log-height helper used by audio_level_meter.
package audio_meter_pkg;
    localparam int SAMPLE_W = 16;
    localparam int HEIGHT_W = 4;
    localparam logic signed [SAMPLE_W-1:0] FULL_SCALE_POS = 16'sh7fff;
    localparam logic signed [SAMPLE_W-1:0] FULL_SCALE_NEG = 16'sh8000;
    typedef logic [SAMPLE_W-2:0] mag_t;
    typedef logic [HEIGHT_W-1:0] height_t;
    // Height is msb_index(g)+1 (0 for g==0), clamped to full bar.
    function automatic height_t log_height(input mag_t g);
        height_t h;
        h = '0;
        for (int i = 0; i < SAMPLE_W - 1; i++)
            if (g[i]) h = (i + 1 >= 2**HEIGHT_W - 1) ? '1 : height_t'(i + 1);
        return h;
    endfunction
endpackage

// File: rtl/audio_level_meter_peak_hold_tracker.sv
// peak_hold_tracker: holds the largest level seen, then steps it down by one
// every HOLD strobes without a new peak (never below the current level).
module peak_hold_tracker #(
    parameter int W    = 4,
    parameter int HOLD = 24000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_strobe,
    input  logic [W-1:0] i_level,
    output logic [W-1:0] o_peak
);
    localparam int CW = $clog2(HOLD + 1);
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_peak;
    logic [W-1:0]  w_dec;
    assign w_dec  = r_peak - 1'b1;
    assign o_peak = r_peak;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_peak <= '0;
            r_cnt  <= '0;
        end else if (i_clr) begin
            r_peak <= '0;
            r_cnt  <= '0;
        end else if (i_strobe) begin
            if (i_level >= r_peak) begin
                r_peak <= i_level;
                r_cnt  <= '0;
            end else if (r_cnt == CW'(HOLD - 1)) begin
                r_peak <= (w_dec > i_level) ? w_dec : i_level;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/audio_level_meter.sv
// audio_level_meter: 2-stage envelope follower (instant attack, periodic proportional
// decay, noise floor) with peak and clip hold. `LEVEL_METER_LOG_EN selects log height.
module audio_level_meter
    import audio_meter_pkg::*;
#(
    parameter int DECAY_SHIFT  = 4,
    parameter int DECAY_DIV    = 48,
    parameter int HOLD_SAMPLES = 24000,
    parameter int NOISE_FLOOR  = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       enable,
    output logic [HEIGHT_W-1:0]        height,
    output logic [HEIGHT_W-1:0]        peak_height,
    output logic                       clip,
    output logic                       level_valid
);
    localparam int   DC_W = $clog2(DECAY_DIV + 1);
    localparam mag_t NF   = mag_t'(NOISE_FLOOR);
    logic                       r_s1_valid, r_clip_hit, r_level_valid;
    logic                       w_clip_hit, w_attack, w_decay_due;
    logic signed [SAMPLE_W-1:0] w_neg;
    mag_t                       r_mag, r_env, w_mag, w_step, w_env_next, w_g;
    logic [DC_W-1:0]            r_decay_cnt;
    height_t                    r_height, w_height;
    always_comb begin
        w_neg       = -sample_in;
        w_mag       = (sample_in == FULL_SCALE_NEG) ? '1 :
                      sample_in[SAMPLE_W-1] ? w_neg[SAMPLE_W-2:0] : sample_in[SAMPLE_W-2:0];
        w_clip_hit  = (sample_in == FULL_SCALE_POS) || (sample_in == FULL_SCALE_NEG);
        w_attack    = r_mag >= r_env;
        w_decay_due = r_decay_cnt == DC_W'(DECAY_DIV - 1);
        // Minimum step of 1 guarantees the envelope always decays to 0.
        w_step      = ((r_env >> DECAY_SHIFT) != '0) ? (r_env >> DECAY_SHIFT) : mag_t'(r_env != '0);
        w_env_next  = w_attack ? r_mag : w_decay_due ? r_env - w_step : r_env;
        w_g         = (w_env_next < NF) ? '0 : w_env_next;
`ifdef LEVEL_METER_LOG_EN
        w_height    = log_height(w_g);
`else
        w_height    = w_g[SAMPLE_W-2 -: HEIGHT_W];
`endif
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_mag      <= '0;
            r_clip_hit <= 1'b0;
        end else begin
            r_s1_valid <= enable & sample_valid;
            if (!enable) begin
                r_mag      <= '0;
                r_clip_hit <= 1'b0;
            end else if (sample_valid) begin
                r_mag      <= w_mag;
                r_clip_hit <= w_clip_hit;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_env         <= '0;
            r_decay_cnt   <= '0;
            r_height      <= '0;
            r_level_valid <= 1'b0;
        end else begin
            r_level_valid <= enable & r_s1_valid;
            if (!enable) begin
                r_env       <= '0;
                r_decay_cnt <= '0;
                r_height    <= '0;
            end else if (r_s1_valid) begin
                r_env       <= w_env_next;
                r_decay_cnt <= (w_attack || w_decay_due) ? '0 : r_decay_cnt + 1'b1;
                r_height    <= w_height;
            end
        end
    end
    peak_hold_tracker #(.W(HEIGHT_W), .HOLD(HOLD_SAMPLES)) u_peak (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (!enable),
        .i_strobe(r_s1_valid),
        .i_level (w_height),
        .o_peak  (peak_height)
    );
    // Clip hold reuses the tracker on a 1-bit level: a hit reloads, HOLD misses clear.
    peak_hold_tracker #(.W(1), .HOLD(HOLD_SAMPLES)) u_clip (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (!enable),
        .i_strobe(r_s1_valid),
        .i_level (r_clip_hit),
        .o_peak  (clip)
    );
    assign height      = r_height;
    assign level_valid = r_level_valid;
endmodule

// File: tb/tb_audio_level_meter.sv
// tb_audio_level_meter: directed stimulus with a scoreboard queue; a negedge
// monitor pops and checks an expected entry on every level_valid pulse.
module tb_audio_level_meter;
`ifdef LEVEL_METER_LOG_EN
    localparam int H16K = 15, H15K = 14, H4K = 13, H256 = 9;
`else
    localparam int H16K = 8, H15K = 7, H4K = 2, H256 = 0;
`endif
    typedef struct {
        int         h;
        int         p;
        int         c;
        logic [2:0] m;
    } exp_t;
    logic               clk = 1'b0, rst = 1'b1, sample_valid = 1'b0, enable = 1'b1;
    logic signed [15:0] sample_in = '0;
    logic [3:0]         height, peak_height;
    logic               clip, level_valid;
    exp_t               sb[$];
    int                 n_tests = 0, n_fail = 0, n_pulse = 0, n_idx = 0;
    audio_level_meter dut (
        .clk         (clk),
        .rst         (rst),
        .sample_valid(sample_valid),
        .sample_in   (sample_in),
        .enable      (enable),
        .height      (height),
        .peak_height (peak_height),
        .clip        (clip),
        .level_valid (level_valid)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask
    initial begin
        forever begin
            @(negedge clk);
            if (level_valid) begin
                n_pulse++;
                if (sb.size() == 0) begin
                    check("unexpected level_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.m[2]) check($sformatf("height #%0d", n_idx), int'(height), e.h);
                    if (e.m[1]) check($sformatf("peak #%0d", n_idx), int'(peak_height), e.p);
                    if (e.m[0]) check($sformatf("clip #%0d", n_idx), int'(clip), e.c);
                end
                n_idx++;
            end
        end
    end
    task automatic send(input int s, input int h, input int p, input int c, input logic [2:0] m);
        exp_t e;
        e.h = h; e.p = p; e.c = c; e.m = m;
        sb.push_back(e);
        sample_valid = 1'b1;
        sample_in    = 16'(s);
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask
    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("scoreboard drained", sb.size(), 0);
    endtask
    task automatic clear();
        drain();
        enable = 1'b0;
        @(posedge clk); #1;
        enable = 1'b1;
    endtask
    initial begin
        int cnt;
        #1;
        check("reset height", int'(height), 0);
        check("reset peak", int'(peak_height), 0);
        check("reset clip", int'(clip), 0);
        check("reset level_valid", int'(level_valid), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        // single strobe with exact latency
        send(16384, H16K, H16K, 0, 3'b111);
        check("latency N+1 level_valid", int'(level_valid), 0);
        @(posedge clk); #1;
        check("latency N+2 level_valid", int'(level_valid), 1);
        drain();
        // async reset mid-pipeline
        sample_valid = 1'b1;
        sample_in    = 16'sh8000;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst height", int'(height), 0);
        check("rst peak", int'(peak_height), 0);
        check("rst clip", int'(clip), 0);
        check("rst level_valid", int'(level_valid), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (level_valid) cnt++;
        end
        @(posedge clk); #1;
        check("pulses after reset release", cnt, 0);
        // clip hold
        send(-32768, 15, 15, 1, 3'b111);
        for (int k = 1; k <= 24000; k++)
            send(0, 15, 15, (k == 24000) ? 0 : 1,
                 (k == 1) ? 3'b111 : (k >= 23999) ? 3'b001 : 3'b000);
        send(32767, 15, 15, 1, 3'b111);
        clear();
        // decay and peak hold
        send(16384, H16K, H16K, 0, 3'b111);
        for (int k = 1; k <= 24047; k++)
            send(0, (k == 47) ? H16K : H15K, (k == 24047) ? H16K - 1 : H16K, 0,
                 (k == 47 || k == 48) ? 3'b111 : (k >= 24046) ? 3'b010 : 3'b000);
        clear();
        // noise floor
        send(200, 0, 0, 0, 3'b111);
        send(-255, 0, 0, 0, 3'b111);
        send(200, 0, 0, 0, 3'b111);
        send(256, H256, H256, 0, 3'b111);
        clear();
        // back-to-back alternating stream
        cnt = n_pulse;
        for (int k = 0; k < 100; k++) send((k % 2) ? -4096 : 4096, H4K, H4K, 0, 3'b111);
        drain();
        check("back-to-back pulse count", n_pulse - cnt, 100);
        // enable low for one cycle, with an ignored strobe
        enable       = 1'b0;
        sample_valid = 1'b1;
        sample_in    = 16'sd30000;
        @(posedge clk); #1;
        check("disabled height", int'(height), 0);
        check("disabled peak", int'(peak_height), 0);
        check("disabled clip", int'(clip), 0);
        check("disabled level_valid", int'(level_valid), 0);
        enable       = 1'b1;
        sample_valid = 1'b0;
        @(posedge clk); #1;
        send(4096, H4K, H4K, 0, 3'b111);
        send(-4096, H4K, H4K, 0, 3'b111);
        drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
